debug_dump_tx: RTL and testbench
================================

// Module: debug_dump_tx
// PURPOSE
//  Debug-unit transmit sequencer sitting directly upstream of the UART transmitter.
//  On a dump request it walks PC, register file (32 words) and data memory (32 words).
//  Each 32-bit word is split into 4 bytes, LSB first, and handed to the UART TX one byte at a time.
//  Total frame: 260 bytes, consumed by the host as PC, then regs 0..31, then mem 0..31.
// PARAMETERS
//  DATA_WIDTH       32  width of PC / register / memory words
//  DATA_WIDTH_UART  8   UART byte width
//  NREGS            32  register words dumped
//  NMEM             32  memory words dumped
//  ADDR_WIDTH       5   width of o_reg_addr / o_mem_addr
// PORTS
//  i_clock         in   1                single clock, all state on rising edge
//  i_reset         in   1                reset, asynchronous, active-low
//  i_start         in   1                dump request; sampled in IDLE only
//  i_pc            in   DATA_WIDTH       current PC, latched on accepted i_start
//  o_reg_addr      out  ADDR_WIDTH       register file read address
//  i_reg_data      in   DATA_WIDTH       register read data, valid 1 cycle after o_reg_addr
//  o_mem_addr      out  ADDR_WIDTH       data memory debug read address
//  i_mem_data      in   DATA_WIDTH       memory read data, valid 1 cycle after o_mem_addr
//  i_tx_available  in   1                UART TX idle / able to accept a byte
//  i_tx_done       in   1                1-cycle pulse: UART finished current byte
//  o_tx_signal     out  1                1-cycle pulse: start transmitting o_tx_byte
//  o_tx_byte       out  DATA_WIDTH_UART  byte to transmit; held stable until i_tx_done
//  o_busy          out  1                high from accepted start until o_done
//  o_done          out  1                1-cycle pulse after last byte's i_tx_done
// BEHAVIOUR
//  Reset (i_reset==0, async): state IDLE; all outputs 0; word buffer, byte_cnt, word_idx, section cleared.
//  Reset mid-dump aborts immediately; no partial-frame resume.
//  Counters:
//   - byte_cnt: 2 bits, 0..3.
//   - word_idx: 6 bits.
//   - section: PC -> REG -> MEM.
//   - o_tx_byte = word_buf[8*byte_cnt +: 8].
//  FSM states and transitions:
//   - IDLE: i_start=1 -> latch i_pc into word_buf, section=PC, byte_cnt=0, o_busy=1 -> SEND.
//   - ADDR: drive o_reg_addr / o_mem_addr = word_idx (other address held 0) -> FETCH next cycle.
//   - FETCH: word_buf <= i_reg_data or i_mem_data by section; byte_cnt=0 -> SEND.
//   - SEND: wait while i_tx_available==0; when 1, o_tx_signal=1 for exactly one cycle -> WAIT.
//   - WAIT: o_tx_signal=0, o_tx_byte stable; on i_tx_done -> NEXT.
//   - NEXT: byte_cnt<3 -> byte_cnt+1, SEND. byte_cnt==3 -> advance word:
//     - PC done -> REG, word_idx=0, ADDR.
//     - REG word_idx<NREGS-1 -> +1, ADDR; else MEM, word_idx=0, ADDR.
//     - MEM word_idx<NMEM-1 -> +1, ADDR; else DONE.
//   - DONE: o_done=1 one cycle, o_busy=0 -> IDLE.
//  Handshake and boundary rules:
//   - i_start while o_busy=1 is ignored (no restart, no queueing).
//   - i_tx_done outside WAIT is ignored.
//   - i_start and reset together: reset wins.
//   - Never more than one byte outstanding; o_tx_signal never asserted twice without an intervening i_tx_done.
//   - Data sampled in FETCH only; source words changing mid-word do not alter bytes already buffered.
//  Minimum latency, i_tx_available constant 1 and i_tx_done immediate:
//   - start -> first o_tx_signal: 1 cycle.
//   - Per new reg/mem word: 2 cycles address+fetch overhead.
// TESTING
//  T1 reset: hold i_reset=0 with i_start=1 -> o_tx_signal=0, o_busy=0, o_done=0, addresses 0.
//  T2 full dump: i_pc=0x00000040, reg k=k*0x01010101, mem k=0xA5000000|k; UART model acks each byte.
//     -> exactly 260 o_tx_signal pulses.
//     -> bytes start 40 00 00 00, 00 00 00 00, 01 01 01 01.
//     -> last 4 bytes 1F 00 00 A5; one o_done pulse.
//  T3 backpressure: i_tx_available=0 for 50 cycles at byte 5 -> no o_tx_signal during stall; byte 5 = 0x00 afterwards, order intact.
//  T4 start while busy: second i_start pulse at byte 100 -> still 260 bytes total, single o_done.
//  T5 reset mid-dump: i_reset=0 at byte 130 -> outputs 0 within same cycle; new i_start restarts with PC byte 0x40.
//  T6 spurious i_tx_done in IDLE/SEND -> no state advance; byte sequence identical to T2.

Source files
------------

// File: rtl/debug_dump_tx.sv
// debug_dump_tx
// Transmit sequencer for the debug unit. It sits in front of the UART transmitter.
// A dump request sends one frame of 260 bytes: the PC, register words 0..31 and
// data memory words 0..31. Each word goes out least-significant byte first, and
// only one byte is ever outstanding at the UART.
module debug_dump_tx #(
  parameter int DATA_WIDTH      = 32,
  parameter int DATA_WIDTH_UART = 8,
  parameter int NREGS           = 32,
  parameter int NMEM            = 32,
  parameter int ADDR_WIDTH      = 5
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_start,
  input  logic [DATA_WIDTH-1:0]      i_pc,
  output logic [ADDR_WIDTH-1:0]      o_reg_addr,
  input  logic [DATA_WIDTH-1:0]      i_reg_data,
  output logic [ADDR_WIDTH-1:0]      o_mem_addr,
  input  logic [DATA_WIDTH-1:0]      i_mem_data,
  input  logic                       i_tx_available,
  input  logic                       i_tx_done,
  output logic                       o_tx_signal,
  output logic [DATA_WIDTH_UART-1:0] o_tx_byte,
  output logic                       o_busy,
  output logic                       o_done
);

  localparam int         BYTES_PER_WORD = DATA_WIDTH / DATA_WIDTH_UART;
  localparam logic [1:0] LAST_BYTE      = 2'(BYTES_PER_WORD - 1);
  localparam logic [5:0] LAST_REG       = 6'(NREGS - 1);
  localparam logic [5:0] LAST_MEM       = 6'(NMEM - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_FETCH,
    S_SEND,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_e;

  typedef enum logic [1:0] {
    SEC_PC,
    SEC_REG,
    SEC_MEM
  } section_e;

  state_e                     state_q;
  section_e                   section_q;
  logic [DATA_WIDTH-1:0]      word_buf_q;
  logic [1:0]                 byte_cnt_q;
  logic [5:0]                 word_idx_q;
  logic [5:0]                 word_idx_d;
  logic [ADDR_WIDTH-1:0]      reg_addr_q;
  logic [ADDR_WIDTH-1:0]      mem_addr_q;
  logic                       tx_signal_q;
  logic                       busy_q;
  logic                       done_q;
  logic [DATA_WIDTH_UART-1:0] tx_byte_d;

  assign word_idx_d = word_idx_q + 6'd1;

  // Select the byte of the buffered word that byte_cnt points at. The selection
  // depends only on registers, so the byte stays stable while the UART shifts it out.
  always_comb begin
    tx_byte_d = '0;
    for (int b = 0; b < BYTES_PER_WORD; b++) begin
      if (byte_cnt_q == 2'(b)) begin
        tx_byte_d = word_buf_q[b*DATA_WIDTH_UART +: DATA_WIDTH_UART];
      end
    end
  end

  // Sequencer FSM. It walks PC, then registers, then memory, one byte at a time.
  // All handshake outputs are registered. The read address is issued on the edge
  // that enters ADDR, so the synchronous read data is valid in FETCH.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q     <= S_IDLE;
      section_q   <= SEC_PC;
      word_buf_q  <= '0;
      byte_cnt_q  <= '0;
      word_idx_q  <= '0;
      reg_addr_q  <= '0;
      mem_addr_q  <= '0;
      tx_signal_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      // Pulse outputs default low. They are raised for one cycle below.
      tx_signal_q <= 1'b0;
      done_q      <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (i_start) begin
            word_buf_q <= i_pc;
            section_q  <= SEC_PC;
            byte_cnt_q <= '0;
            word_idx_q <= '0;
            busy_q     <= 1'b1;
            state_q    <= S_SEND;
          end
        end
        S_ADDR: begin
          state_q <= S_FETCH;
        end
        S_FETCH: begin
          // This is the only point where source data is sampled. Later changes
          // to the source word do not affect bytes that are already buffered.
          word_buf_q <= (section_q == SEC_MEM) ? i_mem_data : i_reg_data;
          byte_cnt_q <= '0;
          state_q    <= S_SEND;
        end
        S_SEND: begin
          if (i_tx_available) begin
            tx_signal_q <= 1'b1;
            state_q     <= S_WAIT;
          end
        end
        S_WAIT: begin
          // i_tx_done is acted on only here. Pulses in any other state have no effect.
          if (i_tx_done) begin
            state_q <= S_NEXT;
          end
        end
        S_NEXT: begin
          if (byte_cnt_q != LAST_BYTE) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            state_q    <= S_SEND;
          end else begin
            case (section_q)
              SEC_PC: begin
                section_q  <= SEC_REG;
                word_idx_q <= '0;
                reg_addr_q <= '0;
                mem_addr_q <= '0;
                state_q    <= S_ADDR;
              end
              SEC_REG: begin
                if (word_idx_q < LAST_REG) begin
                  word_idx_q <= word_idx_d;
                  reg_addr_q <= word_idx_d[ADDR_WIDTH-1:0];
                  mem_addr_q <= '0;
                end else begin
                  section_q  <= SEC_MEM;
                  word_idx_q <= '0;
                  reg_addr_q <= '0;
                  mem_addr_q <= '0;
                end
                state_q <= S_ADDR;
              end
              SEC_MEM: begin
                if (word_idx_q < LAST_MEM) begin
                  word_idx_q <= word_idx_d;
                  mem_addr_q <= word_idx_d[ADDR_WIDTH-1:0];
                  reg_addr_q <= '0;
                  state_q    <= S_ADDR;
                end else begin
                  state_q <= S_DONE;
                end
              end
              default: begin
                state_q <= S_DONE;
              end
            endcase
          end
        end
        S_DONE: begin
          done_q     <= 1'b1;
          busy_q     <= 1'b0;
          reg_addr_q <= '0;
          mem_addr_q <= '0;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_reg_addr  = reg_addr_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_tx_signal = tx_signal_q;
  assign o_tx_byte   = tx_byte_d;
  assign o_busy      = busy_q;
  assign o_done      = done_q;

endmodule

// File: tb/tb_debug_dump_tx.sv
// tb_debug_dump_tx
// Randomised scoreboard bench for debug_dump_tx. A reference model flattens the
// word list (PC, regs, mem) into a byte queue when a dump is started. A monitor
// pops one entry from that queue for every o_tx_signal it sees.
module tb_debug_dump_tx;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_start;
  logic [31:0] i_pc;
  logic [4:0]  o_reg_addr, o_mem_addr;
  logic [31:0] reg_rd, mem_rd;
  logic        avail_rnd, stall, uart_done, spur_done;
  logic        tx_avail, tx_done;
  logic        o_tx_signal, o_busy, o_done;
  logic [7:0]  o_tx_byte;

  assign tx_avail = avail_rnd & ~stall;
  assign tx_done  = uart_done | spur_done;

  debug_dump_tx dut (
    .i_clock       (clk),
    .i_reset       (i_reset),
    .i_start       (i_start),
    .i_pc          (i_pc),
    .o_reg_addr    (o_reg_addr),
    .i_reg_data    (reg_rd),
    .o_mem_addr    (o_mem_addr),
    .i_mem_data    (mem_rd),
    .i_tx_available(tx_avail),
    .i_tx_done     (tx_done),
    .o_tx_signal   (o_tx_signal),
    .o_tx_byte     (o_tx_byte),
    .o_busy        (o_busy),
    .o_done        (o_done)
  );

  int          errors = 0;
  int          checks = 0;
  logic [31:0] regs [32];
  logic [31:0] mems [32];
  logic [31:0] pc_word;
  logic [7:0]  exp_q [$];
  logic [7:0]  log_b [300];
  int          bytes_seen = 0;
  int          done_seen  = 0;
  bit          outstanding = 1'b0;
  int          ack_max = 0;
  bit          rand_avail = 1'b0;
  logic        avail_smp = 1'b0;

  logic [7:0]  first12 [12] = '{8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
                                 8'h01, 8'h01, 8'h01, 8'h01};
  logic [7:0]  last4   [4]  = '{8'h1F, 8'h00, 8'h00, 8'hA5};

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference model: the frame is the word list PC, regs[0..31], mems[0..31],
  // with each word sent as 4 bytes, least-significant byte first.
  function automatic void push_frame();
    logic [31:0] words [$];
    words.push_back(pc_word);
    foreach (regs[k]) words.push_back(regs[k]);
    foreach (mems[k]) words.push_back(mems[k]);
    foreach (words[w])
      for (int b = 0; b < 4; b++) exp_q.push_back(8'(words[w] >> (8 * b)));
  endfunction

  // Synchronous-read register file and data memory.
  always @(posedge clk) begin
    reg_rd <= regs[o_reg_addr];
    mem_rd <= mems[o_mem_addr];
  end

  always @(posedge clk) avail_smp <= tx_avail;

  always @(negedge clk) begin
    #1;
    avail_rnd = rand_avail ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Monitor: scoreboard pop, single-outstanding rule and stall rule.
  always @(negedge clk) begin
    if (i_reset) begin
      if (o_tx_signal) begin
        check("signal_while_unavailable", {31'd0, avail_smp}, 32'd1);
        check("second_byte_outstanding", {31'd0, outstanding}, 32'd0);
        outstanding = 1'b1;
        if (exp_q.size() == 0) begin
          check("unexpected_byte", {24'd0, o_tx_byte}, 32'hFFFF_FFFF);
        end else begin
          check($sformatf("byte[%0d]", bytes_seen), {24'd0, o_tx_byte}, {24'd0, exp_q.pop_front()});
        end
        if (bytes_seen < 300) log_b[bytes_seen] = o_tx_byte;
        bytes_seen++;
      end
      if (o_done) begin
        done_seen++;
        check("busy_low_with_done", {31'd0, o_busy}, 32'd0);
      end
    end
  end

  // UART model: after a random delay, acknowledge each byte and verify the byte
  // stayed stable while it was outstanding.
  logic [7:0] u_cap;
  int         u_d;
  bit         u_abort;
  always begin
    @(negedge clk);
    #1;
    if (i_reset && o_tx_signal) begin
      u_cap   = o_tx_byte;
      u_d     = (ack_max > 0) ? int'($urandom_range(0, ack_max)) : 0;
      u_abort = 1'b0;
      repeat (u_d) begin
        @(negedge clk);
        #1;
        if (!i_reset) u_abort = 1'b1;
      end
      if (!u_abort && i_reset) begin
        check("byte_stable", {24'd0, o_tx_byte}, {24'd0, u_cap});
        outstanding = 1'b0;
        uart_done   = 1'b1;
        @(negedge clk);
        #1;
        uart_done   = 1'b0;
      end
    end
  end

  task automatic load_fixed();
    pc_word = 32'h0000_0040;
    for (int k = 0; k < 32; k++) begin
      regs[k] = 32'(k) * 32'h0101_0101;
      mems[k] = 32'hA500_0000 | 32'(k);
    end
  endtask

  task automatic load_random();
    pc_word = $urandom;
    for (int k = 0; k < 32; k++) begin
      regs[k] = $urandom;
      mems[k] = $urandom;
    end
  endtask

  task automatic start_dump(input bit chk_latency);
    @(negedge clk);
    #2;
    bytes_seen = 0;
    done_seen  = 0;
    i_pc       = pc_word;
    i_start    = 1'b1;
    push_frame();
    @(negedge clk);
    #2;
    i_start = 1'b0;
    if (chk_latency) begin
      check("busy_after_start", {31'd0, o_busy}, 32'd1);
      @(negedge clk);
      #2;
      check("start_to_first_signal", {31'd0, o_tx_signal}, 32'd1);
    end
  endtask

  task automatic wait_bytes(input int n);
    int t = 0;
    while (bytes_seen < n && t < 20000) begin
      @(negedge clk);
      #2;
      t++;
    end
    if (bytes_seen < n) check("timeout_waiting_bytes", 32'(bytes_seen), 32'(n));
  endtask

  task automatic wait_done(input string name);
    int t = 0;
    while (done_seen == 0 && t < 20000) begin
      @(negedge clk);
      t++;
    end
    repeat (10) @(negedge clk);
    check({name, "_byte_count"}, 32'(bytes_seen), 32'd260);
    check({name, "_done_count"}, 32'(done_seen), 32'd1);
    check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    check({name, "_busy_after"}, {31'd0, o_busy}, 32'd0);
  endtask

  task automatic check_outputs_zero(input string name);
    check({name, "_tx_signal"}, {31'd0, o_tx_signal}, 32'd0);
    check({name, "_busy"},      {31'd0, o_busy}, 32'd0);
    check({name, "_done"},      {31'd0, o_done}, 32'd0);
    check({name, "_reg_addr"},  {27'd0, o_reg_addr}, 32'd0);
    check({name, "_mem_addr"},  {27'd0, o_mem_addr}, 32'd0);
    check({name, "_tx_byte"},   {24'd0, o_tx_byte}, 32'd0);
  endtask

  initial begin
    i_reset   = 1'b0;
    i_start   = 1'b1;
    i_pc      = 32'h0000_0040;
    avail_rnd = 1'b1;
    stall     = 1'b0;
    uart_done = 1'b0;
    spur_done = 1'b0;
    load_fixed();

    // Reset is held while start is requested.
    repeat (3) @(negedge clk);
    check_outputs_zero("reset");
    #2;
    i_start = 1'b0;
    i_reset = 1'b1;

    // Spurious done pulses while idle.
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      #2;
      spur_done = (i % 2 == 0);
    end
    spur_done = 1'b0;
    @(negedge clk);
    check("idle_spurious_busy", {31'd0, o_busy}, 32'd0);
    check("idle_spurious_bytes", 32'(bytes_seen), 32'd0);

    // Full dump with a fixed pattern and an immediate UART.
    load_fixed();
    start_dump(1'b1);
    wait_done("full");
    for (int i = 0; i < 12; i++) check($sformatf("full_head[%0d]", i), {24'd0, log_b[i]}, {24'd0, first12[i]});
    for (int i = 0; i < 4; i++) check($sformatf("full_tail[%0d]", i), {24'd0, log_b[256+i]}, {24'd0, last4[i]});

    // Backpressure at byte 5, with spurious done pulses during the stall.
    start_dump(1'b0);
    wait_bytes(5);
    stall = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #2;
      spur_done = (i % 10 == 5);
    end
    spur_done = 1'b0;
    check("stall_no_progress", 32'(bytes_seen), 32'd5);
    stall = 1'b0;
    wait_done("stall");
    check("stall_byte5", {24'd0, log_b[5]}, 32'd0);

    // Random data, random ack delay and random availability, with a second start at byte 100.
    load_random();
    ack_max    = 3;
    rand_avail = 1'b1;
    start_dump(1'b0);
    wait_bytes(100);
    i_start = 1'b1;
    @(negedge clk);
    #2;
    i_start = 1'b0;
    wait_done("restart_ignored");

    // Reset in the middle of a dump, then a clean restart.
    load_random();
    start_dump(1'b0);
    wait_bytes(130);
    i_reset = 1'b0;
    #1;
    check_outputs_zero("mid_reset");
    exp_q.delete();
    outstanding = 1'b0;
    repeat (5) @(negedge clk);
    #2;
    i_reset = 1'b1;
    load_fixed();
    ack_max    = 0;
    rand_avail = 1'b0;
    start_dump(1'b1);
    wait_done("after_reset");
    check("after_reset_first_byte", {24'd0, log_b[0]}, 32'h40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
